// File: rtl/wb_dm_cache.sv
// Direct-mapped write-back/write-allocate line cache between a Wishbone CPU port and memory.
// Define WB_DM_CACHE_PERF_CNT_EN to add saturating hit/miss counters.
module wb_dm_cache #(
  parameter int NUM_SETS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cpu_cyc,
  input  logic         cpu_stb,
  input  logic         cpu_we,
  input  logic [15:0]  cpu_sel,
  input  logic [15:0]  cpu_adr,
  input  logic [127:0] cpu_dat_m,
  output logic [127:0] cpu_dat_s,
  output logic         cpu_ack,
  output logic         mem_cyc,
  output logic         mem_stb,
  output logic         mem_we,
  output logic [15:0]  mem_sel,
  output logic [15:0]  mem_adr,
  output logic [127:0] mem_dat_m,
  input  logic [127:0] mem_dat_s,
  input  logic         mem_ack
`ifdef WB_DM_CACHE_PERF_CNT_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 12 - IDX_W;

  typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, FILL, DONE} state_t;

  state_t state_q, state_d;

  logic [127:0]       data_q [NUM_SETS];
  logic [TAG_W-1:0]   tag_q  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q, dirty_q;

  // Line address of the request, captured when it is accepted in IDLE.
  logic [11:0]        req_line;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   req_tag;
  logic [127:0]       line, merged, rd_line, dat_hold;
  logic               req, hit, latch, line_wr, fill_wr, wb_done;
  logic               unused_offset;

  assign unused_offset = ^cpu_adr[3:0];
  assign req     = cpu_cyc & cpu_stb;
  assign idx     = req_line[IDX_W-1:0];
  assign req_tag = req_line[11:IDX_W];
  assign line    = data_q[idx];
  assign hit     = valid_q[idx] && (tag_q[idx] == req_tag);

  genvar b;
  for (b = 0; b < 16; b++) begin : g_byte
    assign merged[8*b +: 8] = cpu_sel[b] ? cpu_dat_m[8*b +: 8] : line[8*b +: 8];
  end

  assign rd_line   = cpu_we ? merged : line;
  assign cpu_dat_s = cpu_ack ? rd_line : dat_hold;

  always_comb begin
    state_d   = state_q;
    cpu_ack   = 1'b0;
    mem_cyc   = 1'b0;
    mem_stb   = 1'b0;
    mem_we    = 1'b0;
    mem_sel   = 16'h0;
    mem_adr   = 16'h0;
    mem_dat_m = 128'h0;
    latch     = 1'b0;
    line_wr   = 1'b0;
    fill_wr   = 1'b0;
    wb_done   = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        latch   = 1'b1;
        state_d = COMPARE;
      end
      COMPARE: begin
        if (!req) state_d = IDLE;
        else if (hit) begin
          cpu_ack = 1'b1;
          line_wr = cpu_we;
          state_d = DONE;
        end else if (valid_q[idx] && dirty_q[idx]) state_d = WRITEBACK;
        else state_d = FILL;
      end
      WRITEBACK: begin
        mem_cyc   = 1'b1;
        mem_stb   = 1'b1;
        mem_we    = 1'b1;
        mem_sel   = 16'hFFFF;
        mem_adr   = {tag_q[idx], idx, 4'b0};
        mem_dat_m = line;
        if (mem_ack) begin
          wb_done = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        mem_cyc = 1'b1;
        mem_stb = 1'b1;
        mem_sel = 16'hFFFF;
        mem_adr = {req_tag, idx, 4'b0};
        // A withdrawn request still installs the line, then returns to IDLE.
        if (mem_ack) begin
          fill_wr = 1'b1;
          state_d = req ? COMPARE : IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      valid_q  <= '0;
      dirty_q  <= '0;
      req_line <= '0;
      dat_hold <= '0;
    end else begin
      state_q <= state_d;
      if (latch)   req_line <= cpu_adr[15:4];
      if (cpu_ack) dat_hold <= rd_line;
      if (line_wr) dirty_q[idx] <= 1'b1;
      if (wb_done) dirty_q[idx] <= 1'b0;
      if (fill_wr) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_wr) begin
      data_q[idx] <= mem_dat_s;
      tag_q[idx]  <= req_tag;
    end else if (line_wr) begin
      data_q[idx] <= merged;
    end
  end

`ifdef WB_DM_CACHE_PERF_CNT_EN
  // Retry lookups after a fill are not first-pass, so they never count as hits.
  logic first_pass_q, cnt_hit, cnt_miss;

  assign cnt_hit  = (state_q == COMPARE) && req && hit && first_pass_q;
  assign cnt_miss = (state_q == COMPARE) && req && !hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_pass_q <= 1'b0;
      hit_count    <= '0;
      miss_count   <= '0;
    end else begin
      if (latch) first_pass_q <= 1'b1;
      else if (state_q == COMPARE) first_pass_q <= 1'b0;
      if (cnt_hit && hit_count != 32'hFFFF_FFFF)   hit_count  <= hit_count + 32'd1;
      if (cnt_miss && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_dm_cache.sv
// Scoreboarded random + directed bench for wb_dm_cache against a flat-memory reference model.
module tb_wb_dm_cache;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cpu_cyc, cpu_stb, cpu_we;
  logic [15:0]  cpu_sel, cpu_adr;
  logic [127:0] cpu_dat_m, cpu_dat_s;
  logic         cpu_ack;
  logic         mem_cyc, mem_stb, mem_we;
  logic [15:0]  mem_sel, mem_adr;
  logic [127:0] mem_dat_m, mem_dat_s;
  logic         mem_ack;
`ifdef WB_DM_CACHE_PERF_CNT_EN
  logic [31:0]  hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  wb_dm_cache #(.NUM_SETS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_cyc(cpu_cyc), .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_sel(cpu_sel),
    .cpu_adr(cpu_adr), .cpu_dat_m(cpu_dat_m), .cpu_dat_s(cpu_dat_s), .cpu_ack(cpu_ack),
    .mem_cyc(mem_cyc), .mem_stb(mem_stb), .mem_we(mem_we), .mem_sel(mem_sel),
    .mem_adr(mem_adr), .mem_dat_m(mem_dat_m), .mem_dat_s(mem_dat_s), .mem_ack(mem_ack)
`ifdef WB_DM_CACHE_PERF_CNT_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  typedef struct { logic we; logic [15:0] adr; logic [127:0] dat; } txn_t;

  int           n_cmp = 0, n_err = 0;
  int           cyc_cnt = 0, mem_delay = 1, ack_cnt = 0;
  int           last_ack_cyc = 0, mem_ack_cyc = 0;
  logic [127:0] last_dat;
  logic [127:0] bmem    [logic [15:0]];
  logic [127:0] ref_mem [logic [15:0]];
  logic [127:0] exp_q [$];
  txn_t         log_q [$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [127:0] init_line(input logic [15:0] a);
    logic [31:0] x;
    x = {16'h0, a} * 32'h9E37_79B1;
    return {x, ~x, x ^ 32'hA5A5_5A5A, x + 32'h1234_5678};
  endfunction

  function automatic logic [127:0] bmem_get(input logic [15:0] a);
    if (bmem.exists(a)) return bmem[a];
    return init_line(a);
  endfunction

  function automatic logic [127:0] ref_get(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_line(a);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: acks after mem_delay wait cycles, logs every completed transaction.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_dat_s = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (!rst_n || !(mem_cyc && mem_stb)) wait_cnt = 0;
      else if (wait_cnt < mem_delay) wait_cnt++;
      else begin
        wait_cnt = 0;
        chk("mem_sel", mem_sel, 16'hFFFF);
        chk("mem_adr_aligned", mem_adr[3:0], 4'h0);
        if (mem_we) bmem[mem_adr] = mem_dat_m;
        else mem_dat_s = bmem_get(mem_adr);
        log_q.push_back('{mem_we, mem_adr, mem_we ? mem_dat_m : mem_dat_s});
        mem_ack     = 1'b1;
        mem_ack_cyc = cyc_cnt;
      end
    end
  end

  // Response monitor: every cpu_ack pops one expected line.
  always @(negedge clk) begin
    if (rst_n && cpu_ack) begin
      ack_cnt++;
      last_dat = cpu_dat_s;
      if (exp_q.size() == 0) chk("unexpected_ack", 1'b1, 1'b0);
      else chk("ack_line", cpu_dat_s, exp_q.pop_front());
    end
  end

  task automatic cpu_req(input logic we, input logic [15:0] sel, input logic [15:0] adr,
                         input logic [127:0] dat, output int lat);
    logic [127:0] cur;
    logic [15:0]  ln;
    int           issue;
    bit           ok;
    repeat (2) @(negedge clk);
    ln  = {adr[15:4], 4'h0};
    cur = ref_get(ln);
    if (we) begin
      for (int i = 0; i < 16; i++) if (sel[i]) cur[8*i +: 8] = dat[8*i +: 8];
      ref_mem[ln] = cur;
    end
    exp_q.push_back(cur);
    cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = we; cpu_sel = sel; cpu_adr = adr; cpu_dat_m = dat;
    issue = cyc_cnt;
    ok    = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cpu_ack) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("ack_timeout", 1'b0, 1'b1);
      exp_q.delete();
    end
    last_ack_cyc = cyc_cnt;
    lat = cyc_cnt - issue;
    @(posedge clk);
    #1;
    cpu_cyc = 1'b0; cpu_stb = 1'b0;
  endtask

  initial begin
    logic [127:0] l1, wd;
    int           lat, n0, ack0;
    bit           ok;
    cpu_cyc = 0; cpu_stb = 0; cpu_we = 0; cpu_sel = 0; cpu_adr = 0; cpu_dat_m = 0;

    repeat (3) @(negedge clk);
    chk("rst_cpu_ack", cpu_ack, 1'b0);
    chk("rst_cpu_dat_s", cpu_dat_s, 128'h0);
    chk("rst_mem_ctl", {mem_cyc, mem_stb, mem_we}, 3'b000);
    chk("rst_mem_sel", mem_sel, 16'h0);
    chk("rst_mem_adr", mem_adr, 16'h0);
    chk("rst_mem_dat_m", mem_dat_m, 128'h0);
    rst_n = 1'b1;
`ifdef WB_DM_CACHE_PERF_CNT_EN
    chk("rst_counters", {hit_count, miss_count}, 64'h0);
`endif

    l1 = init_line(16'h0010);
    // Cold read miss: a single fill of line 0x0010.
    n0 = log_q.size();
    cpu_req(1'b0, 16'hFFFF, 16'h0012, {4{$urandom}}, lat);
    chk("cold_txn_count", log_q.size() - n0, 1);
    chk("cold_fill", {log_q[n0].we, log_q[n0].adr}, {1'b0, 16'h0010});
    chk("cold_data", last_dat, l1);
    chk("cold_ack_within_2_of_mem_ack",
        (last_ack_cyc - mem_ack_cyc >= 1) && (last_ack_cyc - mem_ack_cyc <= 2), 1'b1);

    // Read hit on the same line.
    n0 = log_q.size();
    cpu_req(1'b0, 16'hFFFF, 16'h001E, 128'h0, lat);
    chk("hit_latency", lat, 1);
    chk("hit_no_mem", log_q.size() - n0, 0);
    chk("hit_data", last_dat, l1);

    // Write hit: bytes 4-5 only.
    wd = {$urandom, $urandom, $urandom, $urandom};
    wd[47:32] = 16'hBEEF;
    n0 = log_q.size();
    cpu_req(1'b1, 16'h0030, 16'h0014, wd, lat);
    chk("wr_hit_latency", lat, 1);
    chk("wr_hit_no_mem", log_q.size() - n0, 0);
    chk("wr_merged_bytes", last_dat[47:32], 16'hBEEF);
    chk("wr_other_bytes", {last_dat[127:48], last_dat[31:0]}, {l1[127:48], l1[31:0]});

    // Conflict read on index 1: writeback of the merged line, then fill.
    n0 = log_q.size();
    cpu_req(1'b0, 16'hFFFF, 16'h0090, 128'h0, lat);
    chk("conflict_txn_count", log_q.size() - n0, 2);
    chk("conflict_wb", {log_q[n0].we, log_q[n0].adr}, {1'b1, 16'h0010});
    chk("conflict_wb_data", log_q[n0].dat, {l1[127:48], 16'hBEEF, l1[31:0]});
    chk("conflict_fill", {log_q[n0+1].we, log_q[n0+1].adr}, {1'b0, 16'h0090});
`ifdef WB_DM_CACHE_PERF_CNT_EN
    chk("perf_hits", hit_count, 32'd2);
    chk("perf_misses", miss_count, 32'd2);
`endif

    // Reset asserted while a fill is outstanding.
    mem_delay = 8;
    n0   = log_q.size();
    ack0 = ack_cnt;
    repeat (2) @(negedge clk);
    cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b0; cpu_sel = 16'hFFFF; cpu_adr = 16'h0010;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_stb && !mem_we) begin ok = 1'b1; break; end
    end
    chk("reset_reached_fill", ok, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mem_drop", {mem_cyc, mem_stb}, 2'b00);
    chk("reset_no_cpu_ack", cpu_ack, 1'b0);
    cpu_cyc = 1'b0; cpu_stb = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ack_count", ack_cnt - ack0, 0);
    chk("reset_no_txn", log_q.size() - n0, 0);
    mem_delay = 1;

    n0 = log_q.size();
    cpu_req(1'b0, 16'hFFFF, 16'h0010, 128'h0, lat);
    chk("post_reset_miss", log_q.size() - n0, 1);
    chk("post_reset_fill", {log_q[n0].we, log_q[n0].adr}, {1'b0, 16'h0010});
`ifdef WB_DM_CACHE_PERF_CNT_EN
    chk("perf_after_reset", {hit_count, miss_count}, {32'd0, 32'd1});
`endif

    // Random traffic over 4 tags x 8 sets.
    for (int t = 0; t < 400; t++) begin
      logic [15:0] a;
      mem_delay = $urandom_range(0, 3);
      a = {7'h0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
      cpu_req(1'($urandom_range(0, 1)), 16'($urandom), a,
              {$urandom, $urandom, $urandom, $urandom}, lat);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
